dial_monitor: RTL
=================

# dial_monitor

Position monitor on the receiving end of the letter-dial stepper interface. It watches the `motor_drv` phase sequence and the `ready` handshake produced by the dial controller and integrates forward and reverse steps into an absolute dial step count. When the controller reports idle, it decodes the count back into a dial position and 7-bit ASCII character and emits a one-cycle `valid` strobe. It sits beside the controller as a self-check and readback path, with no feedback into the motor drive.

## Interface
- `SETTLE_CYC`, default 4: quiet sys_clk cycles required after `ready` rises before the report.
- `sys_clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `motor_drv` input 4: one-hot stepper phase from the controller, 0000 when idle.
- `ready` input 1: controller idle flag, high when no move is pending.
- `ascii_out` output 7: decoded character; reset 7'h20.
- `pos` output 5: decoded dial position 0-31; reset 0.
- `valid` output 1: one-cycle strobe, `ascii_out`/`pos` updated; reset 0.
- `err` output 1: sticky fault flag for the current move; reset 0.

## Operation
- Inputs are sampled into `drv_s` and `rdy_s` (see Configuration). `last_ph` resets to 4'b1000, so the first 0001 is a forward step.
- Step event: `drv_s` becomes non-zero and differs from its previous sampled value. On each event:
  - `drv_s` equals `last_ph` rotated left by 1: forward, `step_cnt` +1.
  - `drv_s` equals `last_ph` rotated right by 1: reverse, `step_cnt` −1.
  - Anything else (same phase re-entered, phase 2 apart, not one-hot): set `err`, no count, `last_ph` takes `drv_s` only if it is one-hot.
- `step_cnt` is 8 bits, range 0-199 (200 steps per revolution). 199+1 gives 0; 0−1 gives 199.
- Dial geometry: 6 steps per letter, 7 steps leaving every position p with p%4==3, so 25 steps per group of 4.
  - q = step_cnt/25, r = step_cnt%25.
  - sub = 3 if r≥18, 2 if r≥12, 1 if r≥6, else 0.
  - pos = 4q+sub.
  - Aligned only when r ∈ {0,6,12,18}; otherwise `err` is set and `pos` holds the lower position.
- Character map:
  - 0 → 7'h20
  - 1-26 → 7'h61-7'h7A
  - 27 and 28 → 7'h20 with `err` set
  - 29 → 7'h2C, 30 → 7'h2E, 31 → 7'h3F
- FSM states: IDLE, MOVING, SETTLE, REPORT.
  - IDLE: `rdy_s`=0 → MOVING, `err` cleared.
  - MOVING: `rdy_s`=1 → SETTLE with the settle counter cleared.
  - SETTLE: the counter increments each cycle with no step event; a step event or `rdy_s`=0 returns to MOVING. Counter = SETTLE_CYC−1 → REPORT.
  - REPORT: for one cycle, `valid`=1, `ascii_out`/`pos` are loaded, `err` includes the alignment check. Then → IDLE.
- Step events are counted in every state. A step event in IDLE (no preceding `ready` low) sets `err`.
- `err` holds until the next IDLE→MOVING transition.

## Timing
- `reset_n` low: all registers go to their reset values immediately, including mid-move. `valid` is never asserted from a move interrupted by reset.
- Each `motor_drv` phase must be held ≥2 sys_clk cycles. Shorter pulses are not guaranteed to be counted.
- Latency from `ready` rising at the pin to `valid` = sync depth + SETTLE_CYC + 1 cycles.
- `step_cnt` updates 1 cycle after a step event is sampled.
- A step event and `ready` rising in the same sample: the step counts, and SETTLE starts on the following cycle.

## Configuration
- `DIAL_MON_SYNC_EN` defined: `motor_drv` and `ready` pass through two-flop synchronizers (sync depth 2), for a controller running on a divided or asynchronous motor clock.
- Not defined: a single input register (sync depth 1); the inputs must be synchronous to `sys_clk`.

## Test plan
- Reset, `ready`=0, phases 0001,0010,0100,1000,0001,0010, then `ready`=1 → after settle, `valid` pulse with `pos`=1, `ascii_out`=7'h61, `err`=0.
- From reset, 7 reverse phases starting 0100 → `step_cnt`=193, `pos`=31, `ascii_out`=7'h3F.
- 200 consecutive forward steps from 0 → wrap to `step_cnt`=0, report `pos`=0, `ascii_out`=7'h20, `err`=0.
- Phase 0001 followed directly by 0100 → `err`=1, `step_cnt` unchanged.
- 3 forward steps, then `ready`=1 → `valid` with `pos`=0, `err`=1.
- Pulse `reset_n` low while MOVING after 10 steps → all outputs at reset values, no `valid`, next move counts from 0.

Source files
------------

// File: rtl/dial_monitor.sv
// Letter-dial position monitor: integrates stepper phase events into an absolute step
// count and reports the decoded dial position/character once the controller settles idle.
// Optional macro DIAL_MON_SYNC_EN selects two-flop input synchronizers (default: one register).
module dial_monitor #(
    parameter int SETTLE_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic [3:0] motor_drv,
    input  logic       ready,
    output logic [6:0] ascii_out,
    output logic [4:0] pos,
    output logic       valid,
    output logic       err
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, MOVING, SETTLE, REPORT} state_t;

    // Returns {char_err, ascii} for a dial position; 27/28 are blank, unused slots.
    function automatic logic [7:0] char_map(input logic [4:0] p);
        logic [7:0] r;
        case (p)
            5'd0:          r = {1'b0, 7'h20};
            5'd27, 5'd28:  r = {1'b1, 7'h20};
            5'd29:         r = {1'b0, 7'h2C};
            5'd30:         r = {1'b0, 7'h2E};
            5'd31:         r = {1'b0, 7'h3F};
            default:       r = {1'b0, 7'h60 + {2'b00, p}};
        endcase
        return r;
    endfunction

    logic [3:0] drv_s;
    logic       rdy_s;

`ifdef DIAL_MON_SYNC_EN
    logic [3:0] drv_meta_q, drv_sync_q;
    logic       rdy_meta_q, rdy_sync_q;

    // Two-flop synchronizers; ready resets high so reset never looks like a move start.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            drv_meta_q <= 4'b0000;
            drv_sync_q <= 4'b0000;
            rdy_meta_q <= 1'b1;
            rdy_sync_q <= 1'b1;
        end else begin
            drv_meta_q <= motor_drv;
            drv_sync_q <= drv_meta_q;
            rdy_meta_q <= ready;
            rdy_sync_q <= rdy_meta_q;
        end
    end
`else
    logic [3:0] drv_sync_q;
    logic       rdy_sync_q;

    // Single input register; ready resets high so reset never looks like a move start.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            drv_sync_q <= 4'b0000;
            rdy_sync_q <= 1'b1;
        end else begin
            drv_sync_q <= motor_drv;
            rdy_sync_q <= ready;
        end
    end
`endif

    assign drv_s = drv_sync_q;
    assign rdy_s = rdy_sync_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [7:0]      step_cnt_q, step_cnt_d;
    logic [3:0]      last_ph_q, last_ph_d;
    logic [3:0]      drv_prev_q, drv_prev_d;
    logic [6:0]      ascii_q, ascii_d;
    logic [4:0]      pos_q, pos_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic            step_ev_s, one_hot_s, bad_step_s, err_set_s;
    logic [3:0]      ph_fwd_s, ph_rev_s;
    logic [2:0]      grp_s;
    logic [4:0]      rem_s;
    logic [1:0]      sub_s;
    logic [4:0]      dec_pos_s;
    logic [6:0]      dec_ascii_s;
    logic            char_err_s, aligned_s;

    assign step_ev_s = (drv_s != 4'b0000) && (drv_s != drv_prev_q);
    assign one_hot_s = (drv_s != 4'b0000) && ((drv_s & (drv_s - 4'd1)) == 4'b0000);
    assign ph_fwd_s  = {last_ph_q[2:0], last_ph_q[3]};
    assign ph_rev_s  = {last_ph_q[0], last_ph_q[3:1]};

    // Dial geometry: 25 steps per group of four letters (6,6,6,7).
    always_comb begin
        grp_s = 3'(step_cnt_q / 8'd25);
        rem_s = 5'(step_cnt_q % 8'd25);
        if (rem_s >= 5'd18) begin
            sub_s = 2'd3;
        end else if (rem_s >= 5'd12) begin
            sub_s = 2'd2;
        end else if (rem_s >= 5'd6) begin
            sub_s = 2'd1;
        end else begin
            sub_s = 2'd0;
        end
        dec_pos_s = {grp_s, sub_s};
        aligned_s = (rem_s == 5'd0) || (rem_s == 5'd6) || (rem_s == 5'd12) || (rem_s == 5'd18);
        {char_err_s, dec_ascii_s} = char_map(dec_pos_s);
    end

    // Next-state logic: step integration plus the settle/report sequencer.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        step_cnt_d = step_cnt_q;
        last_ph_d  = last_ph_q;
        drv_prev_d = drv_s;
        ascii_d    = ascii_q;
        pos_d      = pos_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        bad_step_s = 1'b0;

        if (step_ev_s) begin
            if (drv_s == ph_fwd_s) begin
                step_cnt_d = (step_cnt_q == 8'd199) ? 8'd0 : step_cnt_q + 8'd1;
                last_ph_d  = drv_s;
            end else if (drv_s == ph_rev_s) begin
                step_cnt_d = (step_cnt_q == 8'd0) ? 8'd199 : step_cnt_q - 8'd1;
                last_ph_d  = drv_s;
            end else begin
                bad_step_s = 1'b1;
                last_ph_d  = one_hot_s ? drv_s : last_ph_q;
            end
        end else begin
            bad_step_s = 1'b0;
        end

        // A step seen while idle with ready still high had no move announced.
        err_set_s = bad_step_s || (step_ev_s && (state_q == IDLE) && rdy_s);

        case (state_q)
            IDLE: begin
                if (!rdy_s) begin
                    state_d = MOVING;
                    err_d   = bad_step_s;
                end else begin
                    err_d   = err_q || err_set_s;
                end
            end
            MOVING: begin
                err_d = err_q || err_set_s;
                if (rdy_s) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end else begin
                    state_d  = MOVING;
                end
            end
            SETTLE: begin
                err_d = err_q || err_set_s;
                if (step_ev_s || !rdy_s) begin
                    state_d = MOVING;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = REPORT;
                    valid_d = 1'b1;
                    pos_d   = dec_pos_s;
                    ascii_d = dec_ascii_s;
                    err_d   = err_q || !aligned_s || char_err_s;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            REPORT: begin
                err_d   = err_q || err_set_s;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            step_cnt_q <= 8'd0;
            last_ph_q  <= 4'b1000;
            drv_prev_q <= 4'b0000;
            ascii_q    <= 7'h20;
            pos_q      <= 5'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            step_cnt_q <= step_cnt_d;
            last_ph_q  <= last_ph_d;
            drv_prev_q <= drv_prev_d;
            ascii_q    <= ascii_d;
            pos_q      <= pos_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign ascii_out = ascii_q;
    assign pos       = pos_q;
    assign valid     = valid_q;
    assign err       = err_q;

endmodule
